// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// default NOP payload and the state-to-occupancy mapping.
package pipe_pkg;

  localparam int unsigned PAYLOAD_W = 48;

  // NOP instruction in the low word, both PCs zero.
  localparam logic [PAYLOAD_W-1:0] NOP_PAYLOAD = 48'h0000_0000_0800;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  function automatic logic [1:0] occ_of(input stage_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      EMPTY:   occ = 2'd0;
      HALF:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One payload slot of the stage: enabled register that resets to the
// bubble value so an idle slot never carries stale instruction bits.
module pipe_entry #(
  parameter int unsigned       DATA_W  = 48,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= RST_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshakes and flush.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready;
// otherwise a single entry with a combinational out_ready -> in_ready path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = PAYLOAD_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_PAYLOAD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Handshake: a payload moves on a port only in a cycle where both valid and
  // ready are 1 at the rising edge; valid never depends on ready, and a
  // presented payload stays stable until it is taken.

  stage_state_e      state_q, state_d;
  logic              ready_q, ready_d;
  logic              accept, handoff;
  logic              e0_en;
  logic [DATA_W-1:0] e0_d, e0_q;
`ifdef PIPE_STAGE_SKID_EN
  logic              e1_en;
  logic [DATA_W-1:0] e1_q;
`endif

  assign out_valid = (state_q != EMPTY);
  assign handoff   = out_valid & out_ready;
  assign accept    = in_valid & in_ready;
  assign out_data  = out_valid ? e0_q : BUBBLE_VAL;
  assign occupancy = occ_of(state_q);

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready = ready_q;
`else
  // ready_q only marks "out of reset"; the stall path is combinational.
  assign in_ready = ready_q & (~out_valid | out_ready);
`endif

  always_comb begin
    state_d = state_q;
    e0_en   = 1'b0;
    e0_d    = in_data;
`ifdef PIPE_STAGE_SKID_EN
    e1_en   = 1'b0;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = HALF;
            e0_en   = 1'b1;
          end
        end
        HALF: begin
          if (accept && handoff) begin
            e0_en = 1'b1;
          end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
            // Head is stalled, so the new payload parks in the skid slot.
            state_d = FULL;
            e1_en   = 1'b1;
`else
            e0_en   = 1'b1;
`endif
          end else if (handoff) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (handoff) begin
            state_d = HALF;
            e0_en   = 1'b1;
            e0_d    = e1_q;
          end
`else
          state_d = EMPTY;
`endif
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  assign ready_d = (state_d != FULL);
`else
  assign ready_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  pipe_entry #(
    .DATA_W  (DATA_W),
    .RST_VAL (BUBBLE_VAL)
  ) u_entry0 (
    .clk  (clk),
    .rst  (rst),
    .en_i (e0_en),
    .d_i  (e0_d),
    .q_o  (e0_q)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_entry #(
    .DATA_W  (DATA_W),
    .RST_VAL (BUBBLE_VAL)
  ) u_entry1 (
    .clk  (clk),
    .rst  (rst),
    .en_i (e1_en),
    .d_i  (in_data),
    .q_o  (e1_q)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a random
// run compared against a queue-based model of the stage.
module tb_pipe_stage_reg;

  localparam int unsigned       DATA_W = 48;
  localparam logic [DATA_W-1:0] BUBBLE = 48'h0000_0000_0800;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int n_checks;
  int n_fail;

  // Reference model: payloads held by the stage, oldest first.
  logic [DATA_W-1:0] exp_q[$];
  bit                m_live;

  pipe_stage_reg #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic m_ready();
    if (!m_live) return 1'b0;
    if (CAP == 2) return exp_q.size() < 2;
    return (exp_q.size() == 0) || out_ready;
  endfunction

  function automatic logic [DATA_W-1:0] m_data();
    return (exp_q.size() != 0) ? exp_q[0] : BUBBLE;
  endfunction

  // Driver tasks
  task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    bit acc, hs;
    acc = in_valid && m_ready();
    hs  = (exp_q.size() != 0) && out_ready;
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
      m_live = 1'b0;
    end else begin
      if (flush) begin
        exp_q.delete();
      end else begin
        if (hs) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(in_data);
      end
      m_live = 1'b1;
    end
    #1;
  endtask

  task automatic apply_reset_async();
    rst = 1'b0;
    exp_q.delete();
    m_live = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    drive(1'b1, 48'h1111, 1'b1, 1'b0);
    repeat (3) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_checks++; if (out_data !== BUBBLE) begin n_fail++; $display("FAIL reset_out_data got=%h exp=%h", out_data, BUBBLE); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    drive(1'b0, '0, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_early got=%0b exp=0", in_ready); end
    @(posedge clk); m_live = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL release_occupancy got=%0d exp=0", occupancy); end
  endtask

  task automatic test_single();
    drive(1'b1, 48'h0002_0000_1234, 1'b1, 1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got=%0b exp=1", in_ready); end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got=%0b exp=1", out_valid); end
    n_checks++; if (out_data !== 48'h0002_0000_1234) begin n_fail++; $display("FAIL single_out_data got=%h exp=%h", out_data, 48'h0002_0000_1234); end
    n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL single_occupancy got=%0d exp=1", occupancy); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || out_data !== BUBBLE) begin n_fail++; $display("FAIL single_drain got=%0b/%h exp=0/%h", out_valid, out_data, BUBBLE); end
  endtask

  task automatic test_stall();
    drive(1'b1, 48'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 48'h2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 48'h3, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'(CAP)) begin n_fail++; $display("FAIL stall_occupancy got=%0d exp=%0d", occupancy, CAP); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%0b exp=0", in_ready); end
    n_checks++; if (out_data !== 48'h1) begin n_fail++; $display("FAIL stall_head got=%h exp=1", out_data); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 48'h1) begin n_fail++; $display("FAIL stall_hold got=%0b/%h exp=1/1", out_valid, out_data); end
    drive(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (out_data !== 48'h1) begin n_fail++; $display("FAIL stall_release_a got=%h exp=1", out_data); end
    tick();
    if (CAP == 2) begin
      n_checks++; if (out_data !== 48'h2 || occupancy !== 2'd1) begin n_fail++; $display("FAIL stall_release_b got=%h/%0d exp=2/1", out_data, occupancy); end
      tick();
    end
    n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty got=%0d/%0b exp=0/0", occupancy, out_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < CAP; i++) begin
      drive(1'b1, 48'(32'hA0 + i), 1'b0, 1'b0);
      tick();
    end
    n_checks++; if (occupancy !== 2'(CAP)) begin n_fail++; $display("FAIL flush_fill got=%0d exp=%0d", occupancy, CAP); end
    drive(1'b1, 48'hBEEF, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%0b exp=0", out_valid); end
    n_checks++; if (out_data !== 48'h0000_0000_0800) begin n_fail++; $display("FAIL flush_out_data got=%h exp=%h", out_data, 48'h0000_0000_0800); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] base;
    base = 48'h0000_1000_0000;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, base + 48'(i), 1'b1, 1'b0);
      if (i > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== base + 48'(i - 1) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_%0d got=%0b/%h/%0d/%0b exp=1/%h/1/1", i, out_valid, out_data, occupancy, in_ready, base + 48'(i - 1));
        end
      end
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (out_data !== base + 48'd99) begin n_fail++; $display("FAIL b2b_last got=%h exp=%h", out_data, base + 48'd99); end
    tick();
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL b2b_drain got=%0d exp=0", occupancy); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 48'h77, 1'b0, 1'b0);
    tick();
    drive(1'b1, 48'h78, 1'b0, 1'b0);
    #1 apply_reset_async();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== BUBBLE || occupancy !== 2'd0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid got=%0b/%h/%0d/%0b exp=0/%h/0/0", out_valid, out_data, occupancy, in_ready, BUBBLE);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_recover got=%0b/%0b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_random();
    int transfers;
    transfers = 0;
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), {16'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 2));
      n_checks++;
      if (out_valid !== (exp_q.size() != 0) || out_data !== m_data() || occupancy !== 2'(exp_q.size()) || in_ready !== m_ready()) begin
        n_fail++;
        $display("FAIL random_%0d got=%0b/%h/%0d/%0b exp=%0b/%h/%0d/%0b", i, out_valid, out_data, occupancy, in_ready, (exp_q.size() != 0), m_data(), exp_q.size(), m_ready());
      end
      if (out_valid && out_ready) transfers++;
      tick();
    end
    n_checks++; if (transfers < 100) begin n_fail++; $display("FAIL random_activity got=%0d exp>=100", transfers); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_live    = 1'b0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
